out_bank_arbiter: RTL and testbench

OUT_BANK_ARBITER -- requirements
Module: out_bank_arbiter

---
 rtl/out_bank_pkg.sv | 21 ++
 rtl/out_bank_rr_pick.sv | 61 ++++++
 rtl/out_bank_arbiter.sv | 148 ++++++++++++++
 tb/tb_out_bank_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/out_bank_pkg.sv
// Shared definitions for the output-bank arbiter.
//   state_e       : FSM states, 8-bit encoding
//   SEL_*         : per-requester target codes carried on req_sel
//   DEF_*         : default parameter values for NUM_REQ / DATA_WIDTH
package out_bank_pkg;

  typedef enum logic [7:0] {
    IDLE  = 8'd0,
    WRITE = 8'd1,
    COOL  = 8'd2
  } state_e;

  localparam logic [1:0] SEL_OUT1    = 2'd0;
  localparam logic [1:0] SEL_OUT2    = 2'd1;
  localparam logic [1:0] SEL_OUT3    = 2'd2;
  localparam logic [1:0] SEL_INVALID = 2'd3;

  localparam int unsigned DEF_NUM_REQ    = 3;
  localparam int unsigned DEF_DATA_WIDTH = 32;

endpackage

// File: rtl/out_bank_rr_pick.sv
// Combinational winner selection for the output-bank arbiter.
// Configuration macro: OUT_BANK_ROUND_ROBIN_EN
//   defined   : first requester above ptr wins, searching upward with wrap
//   undefined : lowest requesting index wins, ptr is ignored
// Ports:
//   req    : per-requester request bits
//   ptr    : index of the last winner (round-robin pointer)
//   winner : index of the selected requester
//   valid  : at least one request present
module out_bank_rr_pick
  import out_bank_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

`ifdef OUT_BANK_ROUND_ROBIN_EN
  int unsigned      cand;
  logic [IDX_W-1:0] cidx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    cand   = 0;
    cidx   = '0;
    // Offset 1..NUM_REQ from the pointer; the last candidate is ptr itself.
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(ptr) + k) % NUM_REQ;
      cidx = cand[IDX_W-1:0];
      if (!valid && req[cidx]) begin
        winner = cidx;
        valid  = 1'b1;
      end
    end
  end
`else
  logic             ptr_unused;
  logic [IDX_W-1:0] cidx;

  assign ptr_unused = ^ptr;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    cidx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cidx = k[IDX_W-1:0];
      if (!valid && req[cidx]) begin
        winner = cidx;
        valid  = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/out_bank_arbiter.sv
// Arbitrates NUM_REQ requesters onto a bank of three output registers.
// One write per three cycles: IDLE latches winner/sel/data, WRITE loads the
// register and pulses gnt, COOL clears gnt and returns to IDLE.
// Configuration macro: OUT_BANK_ROUND_ROBIN_EN (round-robin vs fixed priority).
// Ports:
//   clk, reset        : clock, synchronous active-low reset
//   req/req_sel/req_data : per-requester request, target (2b), data
//   gnt               : registered one-hot grant pulse
//   out1/out2/out3    : output register bank
//   busy              : FSM not in IDLE
//   err               : sticky, set by a write to the invalid target
module out_bank_arbiter
  import out_bank_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [2*NUM_REQ-1:0]          req_sel,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [DATA_WIDTH-1:0]         out1,
  output logic [DATA_WIDTH-1:0]         out2,
  output logic [DATA_WIDTH-1:0]         out3,
  output logic                          busy,
  output logic                          err
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        win_q, win_d;
  logic [1:0]              sel_q, sel_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [DATA_WIDTH-1:0]   out1_q, out1_d;
  logic [DATA_WIDTH-1:0]   out2_q, out2_d;
  logic [DATA_WIDTH-1:0]   out3_q, out3_d;
  logic [NUM_REQ-1:0]      gnt_q, gnt_d;
  logic                    err_q, err_d;

  logic [IDX_W-1:0]        pick_win;
  logic                    pick_valid;
  logic [IDX_W-1:0]        pick_ptr;
  logic [IDX_W-1:0]        kidx;

`ifdef OUT_BANK_ROUND_ROBIN_EN
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  assign pick_ptr = ptr_q;
`else
  assign pick_ptr = '0;
`endif

  out_bank_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req    (req),
    .ptr    (pick_ptr),
    .winner (pick_win),
    .valid  (pick_valid)
  );

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    sel_d   = sel_q;
    data_d  = data_q;
    out1_d  = out1_q;
    out2_d  = out2_q;
    out3_d  = out3_q;
    gnt_d   = '0;
    err_d   = err_q;
    kidx    = '0;
`ifdef OUT_BANK_ROUND_ROBIN_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          win_d = pick_win;
          for (int unsigned k = 0; k < NUM_REQ; k++) begin
            kidx = k[IDX_W-1:0];
            if (pick_win == kidx) begin
              sel_d  = req_sel[2*k +: 2];
              data_d = req_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
          end
          state_d = WRITE;
        end
      end
      WRITE: begin
        case (sel_q)
          SEL_OUT1:    out1_d = data_q;
          SEL_OUT2:    out2_d = data_q;
          SEL_OUT3:    out3_d = data_q;
          default:     err_d  = 1'b1;
        endcase
        gnt_d[win_q] = 1'b1;
`ifdef OUT_BANK_ROUND_ROBIN_EN
        ptr_d = win_q;
`endif
        state_d = COOL;
      end
      COOL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      win_q   <= '0;
      sel_q   <= SEL_OUT1;
      data_q  <= '0;
      out1_q  <= '0;
      out2_q  <= '0;
      out3_q  <= '0;
      gnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef OUT_BANK_ROUND_ROBIN_EN
      ptr_q   <= IDX_W'(NUM_REQ - 1);
`endif
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      out1_q  <= out1_d;
      out2_q  <= out2_d;
      out3_q  <= out3_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
`ifdef OUT_BANK_ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign gnt  = gnt_q;
  assign out1 = out1_q;
  assign out2 = out2_q;
  assign out3 = out3_q;
  assign err  = err_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_out_bank_arbiter.sv
// Directed bench for out_bank_arbiter (DATA_WIDTH=32, NUM_REQ=3).
// Inputs are driven and outputs sampled on the falling edge.
module tb_out_bank_arbiter;

  logic        clk;
  logic        reset;
  logic [2:0]  req;
  logic [5:0]  req_sel;
  logic [95:0] req_data;
  logic [2:0]  gnt;
  logic [31:0] out1, out2, out3;
  logic        busy, err;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  out_bank_arbiter #(
    .DATA_WIDTH (32),
    .NUM_REQ    (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_sel  (req_sel),
    .req_data (req_data),
    .gnt      (gnt),
    .out1     (out1),
    .out2     (out2),
    .out3     (out3),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int unsigned i, input logic [1:0] sel, input logic [31:0] d);
    req_sel[2*i +: 2]   = sel;
    req_data[32*i +: 32] = d;
  endtask

  task automatic check_outs(input string tag, input logic [31:0] e1,
                            input logic [31:0] e2, input logic [31:0] e3);
    check({tag, "_out1"}, out1, e1);
    check({tag, "_out2"}, out2, e2);
    check({tag, "_out3"}, out3, e3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] exp_o1;

  initial begin
    reset    = 1'b0;
    req      = '0;
    req_sel  = '0;
    req_data = '0;
    tick; tick;
    check_outs("reset", 32'h0, 32'h0, 32'h0);
    check("reset_gnt", 32'(gnt), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);

    reset = 1'b1;
    tick;
    check("idle_busy", 32'(busy), 32'h0);

    // Single write to out2
    req = 3'b001; set_req(0, 2'd1, 32'h0000_0014);
    tick;
    check("single_e0_busy", 32'(busy), 32'h1);
    check("single_e0_gnt", 32'(gnt), 32'h0);
    check("single_e0_out2", out2, 32'h0);
    tick;
    check_outs("single_e1", 32'h0, 32'h14, 32'h0);
    check("single_e1_gnt", 32'(gnt), 32'h1);
    req = 3'b000;
    tick;
    check("single_e2_gnt", 32'(gnt), 32'h0);
    check("single_e2_busy", 32'(busy), 32'h0);
    tick;
    check("single_idle_out2", out2, 32'h14);

    // Reset pulse between tests, clears the bank
    reset = 1'b0;
    tick;
    reset = 1'b1;
    check("pulse_out2", out2, 32'h0);

    // Contention: all three requesters
    set_req(0, 2'd0, 32'h100);
    set_req(1, 2'd1, 32'h200);
    set_req(2, 2'd2, 32'h300);
    req = 3'b111;
    tick; tick;
    check("cont1_gnt", 32'(gnt), 32'h1);
    check("cont1_out1", out1, 32'h100);
`ifdef OUT_BANK_ROUND_ROBIN_EN
    req = 3'b110;
    tick;
    check("cont1_cool_gnt", 32'(gnt), 32'h0);
    tick; tick;
    check("cont2_gnt", 32'(gnt), 32'h2);
    check("cont2_out2", out2, 32'h200);
    exp_o1 = 32'h100;
`else
    // Requester 0 re-requests right away with new data and wins again
    set_req(0, 2'd0, 32'h101);
    tick;
    check("cont1_cool_gnt", 32'(gnt), 32'h0);
    tick; tick;
    check("cont2_gnt", 32'(gnt), 32'h1);
    check("cont2_out1", out1, 32'h101);
    check("cont2_out2", out2, 32'h0);
    req = 3'b110;
    tick; tick; tick;
    check("cont3_gnt", 32'(gnt), 32'h2);
    check("cont3_out2", out2, 32'h200);
    exp_o1 = 32'h101;
`endif
    req = 3'b100;
    tick; tick; tick;
    check("contl_gnt", 32'(gnt), 32'h4);
    check_outs("contl", exp_o1, 32'h200, 32'h300);
    req = 3'b000;
    tick;
    check("contl_cool_gnt", 32'(gnt), 32'h0);

    // Invalid target
    set_req(1, 2'd3, 32'hDEAD_BEEF);
    req = 3'b010;
    tick;
    check("inv_e0_err", 32'(err), 32'h0);
    tick;
    check("inv_e1_err", 32'(err), 32'h1);
    check("inv_e1_gnt", 32'(gnt), 32'h2);
    check_outs("inv_e1", exp_o1, 32'h200, 32'h300);
    req = 3'b000;
    tick; tick; tick;
    check("inv_sticky_err", 32'(err), 32'h1);

    // Stability: inputs change while the write is in flight
    set_req(0, 2'd2, 32'h55);
    req = 3'b001;
    tick;
    set_req(0, 2'd0, 32'hAA);
    tick;
    check_outs("stab", exp_o1, 32'h200, 32'h55);
    check("stab_gnt", 32'(gnt), 32'h1);
    req = 3'b000;
    tick;
    check("stab_cool_out1", out1, exp_o1);
    tick;

    // Reset during WRITE, then a normal request
    set_req(2, 2'd2, 32'd7);
    req = 3'b100;
    tick;
    check("rstw_busy", 32'(busy), 32'h1);
    reset = 1'b0;
    tick;
    reset = 1'b1;
    check_outs("rstw", 32'h0, 32'h0, 32'h0);
    check("rstw_gnt", 32'(gnt), 32'h0);
    check("rstw_busy_after", 32'(busy), 32'h0);
    check("rstw_err", 32'(err), 32'h0);
    tick;
    check("resume_busy", 32'(busy), 32'h1);
    tick;
    check("resume_out3", out3, 32'd7);
    check("resume_gnt", 32'(gnt), 32'h4);
    req = 3'b000;
    tick;
    check("resume_cool_gnt", 32'(gnt), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
